alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two independent requesters (e.g. two instruction-execution engines).
- Each requester issues {op, a, b} over a valid/ready handshake and receives {result, neg} over its own valid/ready response channel.
- Arbitration is round-robin. A two-stage pipeline accepts at most one operation per cycle.
- Each requester has at most one operation outstanding until its response is consumed.

Parameters:
- OP_W, 2, opcode width; must match ALU OP_CODE.
- DATA_W, 8, operand width; must match ALU A/B.
- RES_W, 16, result width; must match ALU RESULT.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid & ready
- req0_op  in  OP_W  requester 0 opcode
- req0_a  in  DATA_W  requester 0 operand A
- req0_b  in  DATA_W  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meaning, requester 1
- rsp0_valid  out  1  response for requester 0 held
- rsp0_ready  in  1  requester 0 consumes response
- rsp0_result  out  RES_W  ALU RESULT for requester 0's operation
- rsp0_neg  out  1  ALU NEG for requester 0's operation
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_neg  same, requester 1

Behaviour:

Reset (reset==0, asynchronous):
- rsp*_valid=0, rsp*_result=0, rsp*_neg=0.
- busy0=busy1=0, s1_valid=0, last_grant=1 (so requester 0 wins the first tie).
- req*_ready forced 0 while reset==0.
- Reset mid-operation discards in-flight and held operations; no response is produced for them.

Eligibility and arbitration (combinational):
- elig_i = req_i_valid & !busy_i.
- busy_i is set on acceptance and cleared on the response handshake.
- Only one eligible requester: it is granted.
- Both eligible: grant the one != last_grant.
- req_i_ready = grant_i (at most one ready high per cycle).
- req_i_ready may depend on req_i_valid; requesters must not make valid depend on ready.

Edge E0 (accept, req_i_valid & req_i_ready):
- Stage-1 registers load {op, a, b, id=i}; s1_valid=1.
- busy_i=1; last_grant=i.
- With no acceptance: s1_valid=0 and last_grant is unchanged.

Edge E1 (stage-1 valid):
- ALU is driven from the stage-1 registers.
- At E1, rsp_id_result ← ALU RESULT, rsp_id_neg ← ALU NEG, rsp_id_valid=1.
- No write conflict is possible because slot id is reserved by busy_id.

Latency and throughput:
- Latency: response visible in the cycle after E1, 2 clocks after the accept edge.
- Back-to-back accepts from alternating requesters yield 1 op/cycle.
- A single requester is limited to 1 op per (2 + response wait) cycles.

Response hold and handshake:
- rsp_i_result, rsp_i_neg and rsp_i_valid hold stable until rsp_i_valid & rsp_i_ready.
- At that edge: rsp_i_valid=0, busy_i=0. result/neg keep last values.

Boundary conditions:
- Response handshake and new request from the same requester in the same cycle: not accepted; busy is a registered value with no bypass. Accept is possible the next cycle at the earliest.
- rsp_ready high with rsp_valid low has no effect.
- A held response never stalls the other requester.
- req_valid dropped without acceptance leaves no state.
- Operands and opcode are passed unmodified; width rules are those of the ALU.

Decomposition:
- Shared package: OP_W, DATA_W and RES_W constants, plus a requester-id type (1 bit).
- Sub-module: the existing ALU, instantiated once as the shared resource. Its ports are driven only from stage-1 registers.
- Round-robin logic is small; it stays inline and does not warrant a separate module.

Test Plan:
- Reset, then req0 {op=2'b00, a=8'd5, b=8'd3} -> req0_ready=1 in the same cycle. rsp0_valid=1 two clocks later with result/neg equal to a standalone ALU for the same inputs. rsp0_valid holds until rsp0_ready.
- Both valid every cycle (req0 a=8'd10 b=8'd2, req1 a=8'd7 b=8'd9), both rsp_ready=1 -> grants 0,1,... alternate, starting with 0. Responses are routed to the correct requester, never swapped.
- rsp0_ready=0 for 10 cycles while req0 stays valid -> req0_ready stays 0 and requester 1 is still served each eligible cycle. rsp0 values stay stable. After rsp0_ready=1, req0 is accepted no earlier than the following cycle.
- Only req1 valid for 4 transactions, rsp1_ready=1 -> every op is accepted with no starvation by last_grant. Each response arrives 2 clocks after its accept.
- Assert reset=0 one cycle after a req0 accept (s1_valid=1) -> rsp0_valid never asserts for that op. After release, all outputs are 0 and a fresh req0 completes normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared widths, requester id and opcode encodings for the ALU arbiter slice.
package alu_arbiter_pkg;

  localparam int unsigned ALU_OP_W   = 2;
  localparam int unsigned ALU_DATA_W = 8;
  localparam int unsigned ALU_RES_W  = 16;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_AND = 2'b11
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters: add, subtract, multiply, bitwise AND.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   OP_CODE,
  input  logic [ALU_DATA_W-1:0] A,
  input  logic [ALU_DATA_W-1:0] B,
  output logic [ALU_RES_W-1:0]  RESULT,
  output logic                  NEG
);

  always_comb begin
    RESULT = '0;
    NEG    = 1'b0;
    case (OP_CODE)
      ALU_ADD: RESULT = ALU_RES_W'(A) + ALU_RES_W'(B);
      ALU_SUB: begin
        // Two's-complement difference over the full result width.
        RESULT = ALU_RES_W'(A) - ALU_RES_W'(B);
        NEG    = (A < B);
      end
      ALU_MUL: RESULT = ALU_RES_W'(A) * ALU_RES_W'(B);
      ALU_AND: RESULT = ALU_RES_W'(A & B);
      default: RESULT = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters through a two-stage pipeline
// with a per-requester held response slot.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned OP_W   = ALU_OP_W,
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned RES_W  = ALU_RES_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [RES_W-1:0]  rsp0_result,
  output logic              rsp0_neg,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp1_result,
  output logic              rsp1_neg
);

  logic              busy0, busy1;
  req_id_t           last_grant;
  logic              s1_valid;
  req_id_t           s1_id;
  logic [OP_W-1:0]   s1_op;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [RES_W-1:0]  alu_result;
  logic              alu_neg;
  logic              elig0, elig1;
  logic              grant0, grant1;

  assign elig0 = req0_valid & ~busy0;
  assign elig1 = req1_valid & ~busy1;

  // Ready is held low throughout reset regardless of requester state.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      if (elig0 && (!elig1 || last_grant == REQ1)) grant0 = 1'b1;
      else if (elig1)                              grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy0      <= 1'b0;
      busy1      <= 1'b0;
      last_grant <= REQ1;
      s1_valid   <= 1'b0;
      s1_id      <= REQ0;
      s1_op      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
    end else begin
      s1_valid <= grant0 | grant1;
      if (grant0) begin
        s1_op      <= req0_op;
        s1_a       <= req0_a;
        s1_b       <= req0_b;
        s1_id      <= REQ0;
        last_grant <= REQ0;
      end else if (grant1) begin
        s1_op      <= req1_op;
        s1_a       <= req1_a;
        s1_b       <= req1_b;
        s1_id      <= REQ1;
        last_grant <= REQ1;
      end
      // Accept needs !busy, release needs a held response, so they never coincide.
      if (grant0)                       busy0 <= 1'b1;
      else if (rsp0_valid & rsp0_ready) busy0 <= 1'b0;
      if (grant1)                       busy1 <= 1'b1;
      else if (rsp1_valid & rsp1_ready) busy1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_neg    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_neg    <= 1'b0;
    end else begin
      if (s1_valid && s1_id == REQ0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
        rsp0_neg    <= alu_neg;
      end else if (rsp0_valid & rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (s1_valid && s1_id == REQ1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
        rsp1_neg    <= alu_neg;
      end else if (rsp1_valid & rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

  alu_arbiter_alu u_alu (
    .OP_CODE (s1_op),
    .A       (s1_a),
    .B       (s1_b),
    .RESULT  (alu_result),
    .NEG     (alu_neg)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, cycle-by-cycle bench for alu_arbiter with hand-computed expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [7:0]  req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [7:0]  req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_neg;
  logic [15:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready, rsp1_neg;
  logic [15:0] rsp1_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.OP_W(2), .DATA_W(8), .RES_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_neg    (rsp0_neg),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_neg    (rsp1_neg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  t4_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [7:0]  t4_a   [4] = '{8'd1, 8'd0, 8'd255, 8'hF0};
  logic [7:0]  t4_b   [4] = '{8'd2, 8'd1, 8'd255, 8'h3C};
  logic [15:0] t4_res [4] = '{16'h0003, 16'hFFFF, 16'hFE01, 16'h0030};
  logic        t4_neg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic t2_r0 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic t2_r1 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic t2_v0 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic t2_v1 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    reset      = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd0; req0_b = 8'd0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = 8'd0; req1_b = 8'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state, with ready forced low despite a valid request
    repeat (2) tick();
    chk("rst_rsp0_valid",  rsp0_valid,  0);
    chk("rst_rsp1_valid",  rsp1_valid,  0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_neg",    rsp1_neg,    0);
    chk("rst_req0_ready",  req0_ready,  0);
    req0_valid = 1'b0;
    reset      = 1'b1;
    tick();

    // Single op from requester 0: 5 + 3
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd5; req0_b = 8'd3;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_lat_valid", rsp0_valid, 0);
    tick();
    chk("t1_rsp_valid",  rsp0_valid,  1);
    chk("t1_rsp_result", rsp0_result, 16'd8);
    chk("t1_rsp_neg",    rsp0_neg,    0);
    repeat (3) begin
      tick();
      chk("t1_hold_valid",  rsp0_valid,  1);
      chk("t1_hold_result", rsp0_result, 16'd8);
    end
    rsp0_ready = 1'b1;
    tick();
    chk("t1_consumed",   rsp0_valid,  0);
    chk("t1_keep_value", rsp0_result, 16'd8);
    rsp0_ready = 1'b0;

    // Requester 1 alone: four back-to-back transactions
    rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req1_valid = 1'b1; req1_op = t4_op[k]; req1_a = t4_a[k]; req1_b = t4_b[k];
      #1;
      chk("t4_ready", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      #1;
      chk("t4_lat_valid", rsp1_valid, 0);
      tick();
      chk("t4_rsp_valid",  rsp1_valid,  1);
      chk("t4_rsp_result", rsp1_result, t4_res[k]);
      chk("t4_rsp_neg",    rsp1_neg,    t4_neg[k]);
      tick();
      chk("t4_drained", rsp1_valid, 0);
    end

    // Both requesting continuously: alternating grants, responses routed by id
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'd10; req0_b = 8'd2;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 8'd7;  req1_b = 8'd9;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("t2_req0_ready", req0_ready, t2_r0[i]);
      chk("t2_req1_ready", req1_ready, t2_r1[i]);
      chk("t2_rsp0_valid", rsp0_valid, t2_v0[i]);
      chk("t2_rsp1_valid", rsp1_valid, t2_v1[i]);
      if (t2_v0[i]) begin
        chk("t2_rsp0_result", rsp0_result, 16'd8);
        chk("t2_rsp0_neg",    rsp0_neg,    0);
      end
      if (t2_v1[i]) begin
        chk("t2_rsp1_result", rsp1_result, 16'hFFFE);
        chk("t2_rsp1_neg",    rsp1_neg,    1);
      end
      if (i == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
    end
    chk("t2_tail_valid",  rsp1_valid,  1);
    chk("t2_tail_result", rsp1_result, 16'hFFFE);
    tick();

    // Requester 0 response held: requester 1 keeps being served
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 8'd10; req0_b = 8'd2;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'd7;  req1_b = 8'd9;
    #1;
    chk("t3_first_req0", req0_ready, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_req0_blocked", req0_ready, 0);
      chk("t3_req1_ready",   req1_ready, (i % 3) == 0);
      if (i >= 1) begin
        chk("t3_rsp0_valid",  rsp0_valid,  1);
        chk("t3_rsp0_result", rsp0_result, 16'd20);
      end
      if ((i % 3) == 2) begin
        chk("t3_rsp1_valid",  rsp1_valid,  1);
        chk("t3_rsp1_result", rsp1_result, 16'd16);
        chk("t3_rsp1_neg",    rsp1_neg,    0);
      end
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("t3_same_cycle", req0_ready, 0);
    tick();
    chk("t3_next_req0", req0_ready, 1);
    chk("t3_next_req1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("t3_new_valid",  rsp0_valid,  1);
    chk("t3_new_result", rsp0_result, 16'd20);
    tick();

    // Reset one cycle after an accept discards the in-flight op
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'd3; req0_b = 8'd5;
    #1;
    chk("t5_accept", req0_ready, 1);
    tick();
    reset      = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk("t5_rst_valid", rsp0_valid, 0);
    chk("t5_rst_ready", req0_ready, 0);
    repeat (3) begin
      tick();
      chk("t5_no_rsp", rsp0_valid, 0);
    end
    reset = 1'b1;
    #1;
    chk("t5_rsp0_result", rsp0_result, 0);
    chk("t5_rsp0_neg",    rsp0_neg,    0);
    chk("t5_rsp1_valid",  rsp1_valid,  0);
    chk("t5_rsp1_result", rsp1_result, 0);
    tick();
    chk("t5_still_none", rsp0_valid, 0);
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd5; req0_b = 8'd3;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'd1; req1_b = 8'd1;
    #1;
    chk("t5_tie_req0", req0_ready, 1);
    chk("t5_tie_req1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("t5_fresh_valid",  rsp0_valid,  1);
    chk("t5_fresh_result", rsp0_result, 16'd8);
    chk("t5_fresh_neg",    rsp0_neg,    0);
    chk("t5_no_rsp1",      rsp1_valid,  0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
